// File: rtl/pp_gen_pipe.sv
// pp_gen_pipe: two-stage pipelined partial-product generator feeding the Wallace reduction tree.
// Stage S1 holds the operands. Stage S2 holds the registered PP rows and the correction constant.
// Both stages use valid/ready handshakes with lossless backpressure. A counter tracks completed
// output transfers.
module pp_gen_pipe #(
  parameter int unsigned DIM       = 8,
  parameter int unsigned SIGNED_EN = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DIM-1:0]       in_a,
  input  logic [DIM-1:0]       in_b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DIM-1:0]       out_pp [DIM-1:0],
  output logic [2*DIM-1:0]     out_corr,
  output logic                 out_signed,
  output logic [CNT_W-1:0]     out_count
);

  localparam int unsigned PW = 2 * DIM;
  localparam logic [PW-1:0] BW_CORR = (PW'(1) << DIM) | (PW'(1) << (PW - 1));

  // S1 operand stage
  logic [DIM-1:0] s1_a_q, s1_a_d;
  logic [DIM-1:0] s1_b_q, s1_b_d;
  logic           s1_signed_q, s1_signed_d;
  logic           s1_valid_q, s1_valid_d;

  // S2 output stage
  logic [DIM-1:0] pp_q [DIM-1:0];
  logic [DIM-1:0] pp_d [DIM-1:0];
  logic [PW-1:0]  corr_q, corr_d;
  logic           out_signed_q, out_signed_d;
  logic           out_valid_q, out_valid_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [DIM-1:0] pp_calc [DIM-1:0];
  logic [PW-1:0]  corr_calc;
  logic           in_fire, out_fire, s1_adv, signed_in;

  assign signed_in = in_signed & (SIGNED_EN != 0);
  assign s1_adv    = s1_valid_q & (~out_valid_q | out_ready);
  assign in_ready  = ~rst & (~s1_valid_q | s1_adv);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid_q & out_ready;

  // Partial-product rows from S1. In signed mode, bits where exactly one index is DIM-1 are inverted.
  for (genvar gi = 0; gi < DIM; gi++) begin : g_row
    localparam logic [DIM-1:0] INV_MASK = (gi == DIM - 1) ? {1'b0, {(DIM-1){1'b1}}}
                                                          : {1'b1, {(DIM-1){1'b0}}};
    assign pp_calc[gi] = ({DIM{s1_b_q[gi]}} & s1_a_q) ^ (INV_MASK & {DIM{s1_signed_q}});
  end

  assign corr_calc = s1_signed_q ? BW_CORR : '0;

  // Next-state logic for both pipeline stages and the transfer counter
  always_comb begin
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_signed_d  = s1_signed_q;
    s1_valid_d   = s1_valid_q;
    pp_d         = pp_q;
    corr_d       = corr_q;
    out_signed_d = out_signed_q;
    out_valid_d  = out_valid_q;
    count_d      = count_q;

    if (in_fire) begin
      s1_a_d      = in_a;
      s1_b_d      = in_b;
      s1_signed_d = signed_in;
      s1_valid_d  = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d  = 1'b0;
    end

    if (s1_adv) begin
      pp_d         = pp_calc;
      corr_d       = corr_calc;
      out_signed_d = s1_signed_q;
      out_valid_d  = 1'b1;
    end else if (out_fire) begin
      out_valid_d  = 1'b0;
    end

    if (out_fire) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset; all contents are cleared so outputs are never X
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_signed_q  <= 1'b0;
      s1_valid_q   <= 1'b0;
      pp_q         <= '{default: '0};
      corr_q       <= '0;
      out_signed_q <= 1'b0;
      out_valid_q  <= 1'b0;
      count_q      <= '0;
    end else begin
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_signed_q  <= s1_signed_d;
      s1_valid_q   <= s1_valid_d;
      pp_q         <= pp_d;
      corr_q       <= corr_d;
      out_signed_q <= out_signed_d;
      out_valid_q  <= out_valid_d;
      count_q      <= count_d;
    end
  end

  assign out_pp     = pp_q;
  assign out_corr   = corr_q;
  assign out_signed = out_signed_q;
  assign out_valid  = out_valid_q;
  assign out_count  = count_q;

endmodule

// File: tb/tb_pp_gen_pipe.sv
// tb_pp_gen_pipe: self-checking bench for pp_gen_pipe.
// dut0 has signed mode enabled and a 16-bit counter. dut1 has signed mode disabled and a 4-bit
// counter, so counter wrap is reached quickly. Both instances receive the same stimulus.
module tb_pp_gen_pipe;

  localparam int unsigned DIM = 8;
  typedef logic [DIM-1:0] pp_arr_t [DIM-1:0];
  typedef struct { logic [7:0] a; logic [7:0] b; logic s; } txn_t;

  logic clk = 1'b0;
  logic rst, in_valid, in_signed, out_ready;
  logic [7:0] in_a, in_b;
  logic in_ready0, in_ready1, out_valid0, out_valid1, out_signed0, out_signed1;
  pp_arr_t out_pp0, out_pp1;
  logic [15:0] corr0, corr1, count0;
  logic [3:0]  count1;

  int checks = 0;
  int errors = 0;
  txn_t exp_q[$];
  logic [15:0] exp_count = '0;
  bit inf, outf;

  // Outputs captured at the moment of an output handshake
  pp_arr_t cap_pp0, cap_pp1;
  logic [15:0] cap_corr0, cap_corr1;
  logic cap_s0, cap_s1;

  always #5 clk = ~clk;

  pp_gen_pipe #(.DIM(8), .SIGNED_EN(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .out_valid(out_valid0), .out_ready(out_ready), .out_pp(out_pp0),
    .out_corr(corr0), .out_signed(out_signed0), .out_count(count0));

  pp_gen_pipe #(.DIM(8), .SIGNED_EN(0), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .out_valid(out_valid1), .out_ready(out_ready), .out_pp(out_pp1),
    .out_corr(corr1), .out_signed(out_signed1), .out_count(count1));

  // Reference product from plain arithmetic, modulo 2^16
  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [15:0] xa, xb;
    xa = s ? {{8{a[7]}}, a} : {8'h00, a};
    xb = s ? {{8{b[7]}}, b} : {8'h00, b};
    return xa * xb;
  endfunction

  // Product as the reduction tree would form it from rows and correction
  function automatic logic [15:0] recon(input pp_arr_t pp, input logic [15:0] corr);
    logic [15:0] acc;
    acc = corr;
    for (int i = 0; i < DIM; i++) acc = acc + ({8'h00, pp[i]} << i);
    return acc;
  endfunction

  // Settle mid-cycle, then note which handshakes will complete at the next edge
  task automatic sample();
    #1;
    inf  = in_valid && in_ready0;
    outf = out_valid0 && out_ready;
    if (inf) exp_q.push_back('{in_a, in_b, in_signed});
    if (outf) begin
      cap_pp0 = out_pp0; cap_pp1 = out_pp1;
      cap_corr0 = corr0; cap_corr1 = corr1;
      cap_s0 = out_signed0; cap_s1 = out_signed1;
    end
  endtask

  task automatic tick();
    if (outf) exp_count = exp_count + 16'd1;
    @(negedge clk);
  endtask

  // Offer one operand pair with out_ready=1 and wait for its output
  task automatic send_one(input logic [7:0] a, input logic [7:0] b, input logic s,
                          output int lat, output bit got);
    lat = 0; got = 0;
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1; out_ready = 1'b1;
    sample(); tick();
    in_valid = 1'b0;
    for (int k = 1; k < 10 && !got; k++) begin
      sample();
      if (outf) begin
        got = 1; lat = k;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    checks++;
    if (in_ready0 !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready0); end
    checks++;
    if (out_valid0 !== 1'b0 || count0 !== 16'd0 || corr0 !== 16'd0 || out_signed0 !== 1'b0) begin
      errors++; $display("FAIL reset_outputs valid=%b count=%h corr=%h signed=%b want 0", out_valid0, count0, corr0, out_signed0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready0 !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready0); end
    @(negedge clk);
    exp_q.delete(); exp_count = '0;
  endtask

  task automatic test_unsigned();
    int lat; bit got; bit rows_ok;
    send_one(8'hFF, 8'hFF, 1'b0, lat, got);
    checks++;
    if (!got || lat != 2) begin errors++; $display("FAIL unsigned_latency got=%0b lat=%0d want lat=2", got, lat); end
    rows_ok = 1;
    for (int i = 0; i < DIM; i++) if (cap_pp0[i] !== 8'hFF) rows_ok = 0;
    checks++;
    if (!rows_ok) begin errors++; $display("FAIL unsigned_rows row0=%h row7=%h want all ff", cap_pp0[0], cap_pp0[7]); end
    checks++;
    if (cap_corr0 !== 16'h0000 || cap_s0 !== 1'b0) begin
      errors++; $display("FAIL unsigned_corr corr=%h signed=%b want 0000/0", cap_corr0, cap_s0);
    end
    checks++;
    if (recon(cap_pp0, cap_corr0) !== 16'hFE01) begin
      errors++; $display("FAIL unsigned_product got=%h want=fe01", recon(cap_pp0, cap_corr0));
    end
  endtask

  task automatic test_signed();
    int lat; bit got; bit rows_ok;
    send_one(8'h80, 8'hFF, 1'b1, lat, got);
    checks++;
    if (!got) begin errors++; $display("FAIL signed_timeout got=0 want output"); end
    rows_ok = (cap_pp0[7] === 8'hFF);
    for (int i = 0; i < DIM - 1; i++) if (cap_pp0[i] !== 8'h00) rows_ok = 0;
    checks++;
    if (!rows_ok) begin errors++; $display("FAIL signed_rows row0=%h row6=%h row7=%h want 00/00/ff", cap_pp0[0], cap_pp0[6], cap_pp0[7]); end
    checks++;
    if (cap_corr0 !== 16'h8100 || cap_s0 !== 1'b1) begin
      errors++; $display("FAIL signed_corr corr=%h signed=%b want 8100/1", cap_corr0, cap_s0);
    end
    checks++;
    if (recon(cap_pp0, cap_corr0) !== 16'h0080) begin
      errors++; $display("FAIL signed_product got=%h want=0080", recon(cap_pp0, cap_corr0));
    end
  endtask

  task automatic test_signed_disabled();
    int lat; bit got;
    send_one(8'h80, 8'hFF, 1'b1, lat, got);
    checks++;
    if (!got || cap_s1 !== 1'b0 || cap_corr1 !== 16'h0000) begin
      errors++; $display("FAIL sgn_dis_flags got=%0b signed=%b corr=%h want 0/0000", got, cap_s1, cap_corr1);
    end
    checks++;
    if (recon(cap_pp1, cap_corr1) !== 16'h7F80) begin
      errors++; $display("FAIL sgn_dis_product got=%h want=7f80", recon(cap_pp1, cap_corr1));
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0, rcvd = 0, first_acc = -1, first_out = -1, last_out = -1, bad = 0, gaps = 0;
    txn_t e;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && rcvd < 16; cyc++) begin
      in_valid = (sent < 16);
      in_a = 8'($urandom); in_b = 8'($urandom); in_signed = 1'($urandom);
      if (cyc == 1) begin in_a = 8'h80; in_b = 8'h7F; end
      sample();
      if (inf) begin if (first_acc < 0) first_acc = cyc; sent++; end
      if (outf) begin
        if (first_out < 0) first_out = cyc;
        if (last_out >= 0 && cyc != last_out + 1) gaps++;
        last_out = cyc;
        rcvd++;
        e = exp_q.pop_front();
        checks++;
        if (recon(cap_pp0, cap_corr0) !== ref_prod(e.a, e.b, e.s) || cap_s0 !== e.s ||
            cap_corr0 !== (e.s ? 16'h8100 : 16'h0000)) begin
          errors++; bad++;
          $display("FAIL stream_dut0 a=%h b=%h s=%b got=%h want=%h", e.a, e.b, e.s,
                   recon(cap_pp0, cap_corr0), ref_prod(e.a, e.b, e.s));
        end
        checks++;
        if (recon(cap_pp1, cap_corr1) !== ref_prod(e.a, e.b, 1'b0) || cap_s1 !== 1'b0) begin
          errors++; bad++;
          $display("FAIL stream_dut1 a=%h b=%h got=%h want=%h", e.a, e.b,
                   recon(cap_pp1, cap_corr1), ref_prod(e.a, e.b, 1'b0));
        end
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (rcvd != 16 || first_out - first_acc != 2 || gaps != 0) begin
      errors++; $display("FAIL stream_timing rcvd=%0d latency=%0d gaps=%0d want 16/2/0", rcvd, first_out - first_acc, gaps);
    end
    #1;
    checks++;
    if (count0 !== exp_count || count1 !== exp_count[3:0]) begin
      errors++; $display("FAIL stream_count got=%0d/%0d want=%0d/%0d", count0, count1, exp_count, exp_count[3:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    txn_t p [3];
    txn_t e;
    int sent = 0, rcvd = 0, acc_early = 0;
    for (int i = 0; i < 3; i++) p[i] = '{8'($urandom), 8'($urandom), 1'($urandom)};
    for (int cyc = 0; cyc < 20 && rcvd < 3; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid = (sent < 3);
      if (sent < 3) begin in_a = p[sent].a; in_b = p[sent].b; in_signed = p[sent].s; end
      sample();
      if (inf) sent++;
      if (cyc == 3) acc_early = sent;
      if (cyc == 2 || cyc == 3) begin
        checks++;
        if (in_ready0 !== 1'b0 || out_valid0 !== 1'b1) begin
          errors++; $display("FAIL bp_full cyc=%0d in_ready=%b out_valid=%b want 0/1", cyc, in_ready0, out_valid0);
        end
        checks++;
        if (recon(out_pp0, corr0) !== ref_prod(p[0].a, p[0].b, p[0].s)) begin
          errors++; $display("FAIL bp_held cyc=%0d got=%h want=%h", cyc, recon(out_pp0, corr0), ref_prod(p[0].a, p[0].b, p[0].s));
        end
      end
      if (outf) begin
        rcvd++;
        e = exp_q.pop_front();
        checks++;
        if (recon(cap_pp0, cap_corr0) !== ref_prod(e.a, e.b, e.s) || e.a !== p[rcvd-1].a || e.b !== p[rcvd-1].b) begin
          errors++; $display("FAIL bp_order idx=%0d got=%h want=%h", rcvd - 1, recon(cap_pp0, cap_corr0), ref_prod(p[rcvd-1].a, p[rcvd-1].b, p[rcvd-1].s));
        end
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (acc_early != 2 || rcvd != 3) begin
      errors++; $display("FAIL bp_counts accepted=%0d rcvd=%0d want 2/3", acc_early, rcvd);
    end
  endtask

  task automatic test_reset_midflight();
    bit zero_ok;
    int lat; bit got;
    out_ready = 1'b0; in_valid = 1'b1; in_signed = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_a = 8'($urandom); in_b = 8'($urandom);
      sample(); tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready0 !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got=%b want=0", in_ready0); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    zero_ok = 1;
    for (int i = 0; i < DIM; i++) if (out_pp0[i] !== 8'h00) zero_ok = 0;
    checks++;
    if (out_valid0 !== 1'b0 || count0 !== 16'd0 || !zero_ok || corr0 !== 16'd0) begin
      errors++; $display("FAIL midrst_state valid=%b count=%h pp_zero=%0b corr=%h want 0", out_valid0, count0, zero_ok, corr0);
    end
    checks++;
    if (in_ready0 !== 1'b1) begin errors++; $display("FAIL midrst_release got=%b want=1", in_ready0); end
    @(negedge clk);
    exp_q.delete(); exp_count = '0;
    send_one(8'h05, 8'h07, 1'b0, lat, got);
    checks++;
    if (!got || recon(cap_pp0, cap_corr0) !== 16'd35) begin
      errors++; $display("FAIL midrst_fresh got=%0b prod=%h want 0023", got, recon(cap_pp0, cap_corr0));
    end
    #1;
    checks++;
    if (count0 !== 16'd1 || out_valid0 !== 1'b0) begin
      errors++; $display("FAIL midrst_count got=%0d valid=%b want 1/0", count0, out_valid0);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_unsigned();
    test_signed();
    test_signed_disabled();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
